seg_scanner: RTL and testbench
==============================

# seg_scanner

Time-multiplexed seven-segment display driver for the pseudo-terminal front panel. It consumes the 10 kHz square wave from the clock divider as a scan rate, not as a clock. On each rising edge of that wave it steps to the next digit, with a one-cycle anti-ghosting blank between digits, and drives one-hot anodes plus hex-decoded cathodes. Digit data is snapshotted once per frame so a refresh never shows a half-updated value.

## Interface
- `NUM_DIGITS`, 8: digits scanned, 2..16.
- `ACTIVE_LOW`, 1: 1 means anodes, segments and `dp` are asserted low; 0 means asserted high.
- `clk`  in  1  100 MHz system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `scan_clk`  in  1  10 kHz square wave from the divider, generated in the `clk` domain; treated as data.
- `digits`  in  4*NUM_DIGITS  hex nibbles; digit i is `digits[4i+3:4i]`, digit 0 is rightmost.
- `dp_in`  in  NUM_DIGITS  decimal point request per digit.
- `blank_in`  in  NUM_DIGITS  1 forces that digit dark.
- `an`  out  NUM_DIGITS  one-hot anode enables.
- `seg`  out  7  cathodes; `seg[0]`=a through `seg[6]`=g.
- `dp`  out  1  decimal point cathode.
- `frame_start`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- `scan_q` registers `scan_clk`. `tick` = `scan_clk & ~scan_q`, giving one tick per 10 000 `clk` cycles.
- State machine:
  - IDLE: entered on reset; all outputs inactive. On `tick`, go to BLANK with `idx` = 0 and take a snapshot.
  - BLANK: lasts one cycle with all outputs inactive, then go to SHOW.
  - SHOW: drive digit `idx`. On `tick`, go to BLANK and advance `idx` = (`idx`+1) mod `NUM_DIGITS`. Wrapping to 0 takes a new snapshot.
- Snapshot: `digits`, `dp_in` and `blank_in` are captured into internal registers, and `frame_start` pulses in the same cycle. SHOW uses only the snapshot.
- SHOW outputs:
  - `an` asserts bit `idx` only.
  - `seg` is the hex decode of `snap_digits[idx]`.
  - `dp` is `snap_dp[idx]`.
  - If `snap_blank[idx]`, then `an` stays asserted but `seg` and `dp` are inactive.
- Hex decode, as active-high gfedcba:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07
  - 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71
  - All bits are inverted when `ACTIVE_LOW`.
- Reset values:
  - `an`, `seg` and `dp` all inactive: all ones when `ACTIVE_LOW`=1, zeros otherwise.
  - `frame_start`=0, `idx`=0, `scan_q`=0, snapshot cleared, state IDLE.
- Boundary conditions:
  - `scan_clk` stuck high or low: no ticks are generated and the current digit stays lit indefinitely.
  - `reset` mid-frame: outputs go inactive immediately, without waiting for a clock edge. After release, the first tick restarts at digit 0 with a fresh snapshot.
  - `reset` deasserted while `scan_clk`=1: `scan_q` is 0, so that edge still counts as a tick.
  - Input changes mid-frame: not shown until the next wrap.

## Timing
- `tick` is true in the cycle before clock edge k.
- At edge k: state becomes BLANK, `an` goes inactive, and `idx` and the snapshot update. For a snapshot, `frame_start`=1 during cycle k..k+1.
- At edge k+1: state becomes SHOW, and `an`, `seg` and `dp` show the new digit. All outputs are registered.
- Digit period is 100 µs. Frame period is `NUM_DIGITS`×100 µs, i.e. 800 µs or 1.25 kHz at the default.
- The BLANK gap is exactly 1 cycle (10 ns) per digit.

## Configuration
- `SEG_LEADING_ZERO_BLANK_EN`
  - Defined: at snapshot time, every digit more significant than the highest nonzero digit is added to `snap_blank`. Digit 0 is never auto-blanked.
  - Undefined: only `blank_in` controls blanking.

## Structure
- Package `seg_scanner_pkg`:
  - state enum (IDLE, BLANK, SHOW)
  - the 16-entry active-high hex segment constant table
  - `SEG_W`=7
- Sub-module `hex_to_seg`: combinational nibble-to-gfedcba decoder, active-high. Polarity inversion happens in `seg_scanner`.

## Test plan
- Reset asserted with `ACTIVE_LOW`=1 → `an`=8'hFF, `seg`=7'h7F, `dp`=1, `frame_start`=0; async reset during SHOW → same values before the next `clk` edge.
- `digits`=32'h89AB_CDEF with 8 ticks → one cycle with `an`=8'hFF after each tick, then `an`=8'hFE with `seg`=~7'h71, then `an`=8'hFD with `seg`=~7'h79, and so on through digit 7 = ~7'h7F.
- Change `digits` while digit 3 is shown → digits 4..7 keep the old values; new values appear after the next `frame_start`.
- `blank_in`=8'h01 and `dp_in`=8'h02 → digit 0 has `an` asserted with `seg`=7'h7F; digit 1 has `dp`=0.
- Hold `scan_clk` high for 50 000 cycles → `an` is unchanged and `frame_start` stays 0.
- With `SEG_LEADING_ZERO_BLANK_EN`, `digits`=32'h0000_0400 → digits 3..7 show `seg`=7'h7F; digits 0..1 show "0" (~7'h3F); digit 2 shows "4" (~7'h66).

Source files
------------

// File: rtl/seg_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM state,
// segment width and the active-high gfedcba hex font.
package seg_scanner_pkg;

  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Entry n is the active-high gfedcba pattern for hex digit n (index 15 first).
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scanner_hex_to_seg.sv
// Combinational nibble-to-gfedcba decoder, active-high outputs.
module hex_to_seg
  import seg_scanner_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed seven-segment scanner with per-frame input snapshot.
// Optional: define SEG_LEADING_ZERO_BLANK_EN to auto-blank leading zeros.
module seg_scanner
  import seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [SEG_W-1:0]        seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int                IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic              POL      = (ACTIVE_LOW != 0);

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic                          scan_q;
  logic                          tick;
  logic                          take_snap;
  logic [NUM_DIGITS-1:0][3:0]    snap_digits;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic [NUM_DIGITS-1:0]         snap_blank;
  logic [NUM_DIGITS-1:0]         lz_mask;
  logic [NUM_DIGITS-1:0]         onehot;
  logic [SEG_W-1:0]              dec_seg;

  // scan_clk is data in the clk domain; a rising edge is a scan step.
  assign tick      = scan_clk & ~scan_q;
  assign take_snap = tick && ((state == ST_IDLE) ||
                              (state == ST_SHOW && idx == LAST_IDX));

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digits above the highest nonzero digit go dark; digit 0 always shows.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digits[4*i +: 4] != 4'h0) seen = 1'b1;
      lz_mask[i] = ~seen;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  hex_to_seg u_dec (
    .nibble (snap_digits[idx]),
    .seg    (dec_seg)
  );

  // NOTE: the snapshot registers are reset explicitly even though they behave
  // like storage, so a frame can never show power-up garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
    end else if (take_snap) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_blank  <= blank_in | lz_mask;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      scan_q      <= 1'b0;
      frame_start <= 1'b0;
      an          <= {NUM_DIGITS{POL}};
      seg         <= {SEG_W{POL}};
      dp          <= POL;
    end else begin
      scan_q      <= scan_clk;
      frame_start <= take_snap;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state <= ST_BLANK;
            idx   <= '0;
          end
        end
        ST_BLANK: begin
          state <= ST_SHOW;
          an    <= onehot ^ {NUM_DIGITS{POL}};
          seg   <= (snap_blank[idx] ? '0 : dec_seg) ^ {SEG_W{POL}};
          dp    <= (snap_dp[idx] & ~snap_blank[idx]) ^ POL;
        end
        ST_SHOW: begin
          if (tick) begin
            state <= ST_BLANK;
            an    <= {NUM_DIGITS{POL}};
            seg   <= {SEG_W{POL}};
            dp    <= POL;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          an    <= {NUM_DIGITS{POL}};
          seg   <= {SEG_W{POL}};
          dp    <= POL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner (8 digits, active-low) with a scoreboard
// of expected digit outputs pushed per tick and popped when SHOW appears.
module tb_seg_scanner;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          scan_clk;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank_in;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_start;

  seg_scanner #(.NUM_DIGITS(N), .ACTIVE_LOW(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_clk    (scan_clk),
    .digits      (digits),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   errors = 0;
  int   checks = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model of the scan position and captured frame
  bit           m_running = 1'b0;
  int           m_idx = 0;
  bit           m_fs = 1'b0;
  logic [4*N-1:0] m_dig = '0;
  logic [N-1:0] m_dp = '0;
  logic [N-1:0] m_blank = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] lz_of(input logic [4*N-1:0] d);
    logic [N-1:0] m;
    bit seen;
    m = '0;
    seen = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    for (int i = N - 1; i >= 1; i--) begin
      if (d[4*i +: 4] != 4'h0) seen = 1'b1;
      m[i] = !seen;
    end
`endif
    return m;
  endfunction

  task automatic model_tick();
    exp_t e;
    logic [3:0] d;
    m_fs = 1'b0;
    if (!m_running || m_idx == N - 1) begin
      m_running = 1'b1;
      m_idx     = 0;
      m_dig     = digits;
      m_dp      = dp_in;
      m_blank   = blank_in | lz_of(digits);
      m_fs      = 1'b1;
    end else begin
      m_idx++;
    end
    d    = m_dig[4*m_idx +: 4];
    e.an = ~(N'(1) << m_idx);
    if (m_blank[m_idx]) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end else begin
      e.seg = ~hex_tbl[d];
      e.dp  = ~m_dp[m_idx];
    end
    sb.push_back(e);
  endtask

  // Sample the BLANK cycle after edge k, then the SHOW cycle after edge k+1.
  task automatic observe(input bit hold);
    exp_t e;
    @(posedge clk); #1;
    check("blank_an", 32'(an), 32'hFF);
    check("blank_seg", 32'(seg), 32'h7F);
    check("frame_start", 32'(frame_start), 32'(m_fs));
    @(negedge clk);
    if (!hold) scan_clk = 1'b0;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed=0 entries expected=1");
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check($sformatf("an_d%0d", m_idx), 32'(an), 32'(e.an));
      check($sformatf("seg_d%0d", m_idx), 32'(seg), 32'(e.seg));
      check($sformatf("dp_d%0d", m_idx), 32'(dp), 32'(e.dp));
      check("fs_clear", 32'(frame_start), 32'h0);
    end
  endtask

  task automatic tick_step(input bit hold);
    @(negedge clk);
    scan_clk = 1'b1;
    model_tick();
    observe(hold);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit fs_seen;
    bit an_moved;
    reset    = 1'b1;
    scan_clk = 1'b0;
    digits   = 32'h89AB_CDEF;
    dp_in    = '0;
    blank_in = '0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_fs", 32'(frame_start), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_an", 32'(an), 32'hFF);

    // Frame 1: plain hex digits
    for (int i = 0; i < N; i++) tick_step(1'b0);

    // Frame 2: inputs change while digit 3 is lit, old frame must persist
    for (int i = 0; i < 4; i++) tick_step(1'b0);
    digits = 32'h1234_5678;
    for (int i = 0; i < 4; i++) tick_step(1'b0);

    // Frame 3: new digits, plus blanking and decimal point requests
    blank_in = 8'h01;
    dp_in    = 8'h02;
    for (int i = 0; i < N; i++) tick_step(1'b0);
    blank_in = '0;
    dp_in    = '0;

    // scan_clk stuck high after one edge: display must freeze
    tick_step(1'b1);
    fs_seen  = 1'b0;
    an_moved = 1'b0;
    for (int i = 0; i < 50000; i++) begin
      @(negedge clk);
      if (frame_start !== 1'b0) fs_seen = 1'b1;
      if (an !== last_exp.an) an_moved = 1'b1;
    end
    check("stuck_fs", 32'(fs_seen), 32'h0);
    check("stuck_an", 32'(an_moved), 32'h0);
    check("stuck_an_val", 32'(an), 32'(last_exp.an));
    @(negedge clk);
    scan_clk = 1'b0;
    repeat (3) @(negedge clk);

    tick_step(1'b0);
    tick_step(1'b0);

    // Async reset mid-SHOW: outputs go dark before the next clk edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hFF);
    check("arst_seg", 32'(seg), 32'h7F);
    check("arst_dp", 32'(dp), 32'h1);
    check("arst_fs", 32'(frame_start), 32'h0);
    digits   = 32'h0000_0400;
    scan_clk = 1'b1;
    repeat (3) @(negedge clk);
    // Release with scan_clk already high: that level still counts as a tick
    reset     = 1'b0;
    m_running = 1'b0;
    model_tick();
    observe(1'b0);
    for (int i = 1; i < N; i++) tick_step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
